// File: rtl/filter_decimator16_pkg.sv
// Shared widths, saturation limits and the exponent clamp helper for the
// decimating block-averager and its neighbouring filter stages.
package filter_decimator_pkg;
    localparam int IN_W     = 32;
    localparam int OUT_W    = 16;
    localparam int LOG2_MAX = 8;
    localparam int ACC_W    = IN_W + LOG2_MAX;
    localparam int CNT_W    = LOG2_MAX + 1;
    localparam int K_W      = 4;
    localparam int OUT_MAX  = (1 << (OUT_W - 1)) - 1;
    localparam int OUT_MIN  = -(1 << (OUT_W - 1));

    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic                    sat;
    } dec_res_t;

    // Exponents above LOG2_MAX behave as LOG2_MAX.
    function automatic logic [K_W-1:0] clamp_k(input logic [K_W-1:0] k);
        return (int'(k) > LOG2_MAX) ? K_W'(LOG2_MAX) : k;
    endfunction
endpackage

// File: rtl/filter_decimator16_if.sv
// Sample input stream, result output stream and overflow status of the
// decimator, bundled for the decimator (slave) and its environment (master).
interface filter_decimator16_if;
    import filter_decimator_pkg::*;

    logic signed [IN_W-1:0]  i_data;
    logic                    i_valid;
    logic [K_W-1:0]          i_log2_dec;
    logic                    i_ready;
    logic                    i_clr_ovf;
    logic signed [OUT_W-1:0] o_data;
    logic                    o_sat;
    logic                    o_valid;
    logic                    o_ovf;

    modport slave (
        input  i_data, i_valid, i_log2_dec, i_ready, i_clr_ovf,
        output o_data, o_sat, o_valid, o_ovf
    );

    modport master (
        output i_data, i_valid, i_log2_dec, i_ready, i_clr_ovf,
        input  o_data, o_sat, o_valid, o_ovf
    );
endinterface

// File: rtl/filter_decimator16_dec_sat_shift.sv
// Divides an accumulated block sum by 2^k (floor toward -inf) and clamps the
// quotient to the signed output range, flagging when the clamp engaged.
module dec_sat_shift
    import filter_decimator_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_sum,
    input  logic [K_W-1:0]          i_k,
    output dec_res_t                o_res
);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(OUT_MIN);

    logic signed [ACC_W-1:0] w_shift;

    assign w_shift = i_sum >>> i_k;

    always_comb begin
        o_res.sat  = 1'b1;
        o_res.data = OUT_W'(w_shift);
        if (w_shift > SAT_HI) begin
            o_res.data = OUT_W'(OUT_MAX);
        end else if (w_shift < SAT_LO) begin
            o_res.data = OUT_W'(OUT_MIN);
        end else begin
            o_res.sat = 1'b0;
        end
    end
endmodule

// File: rtl/filter_decimator16.sv
// Block-averaging decimator: sums 2^k input samples, emits the saturated
// average on a valid/ready port and flags results lost to backpressure.
module filter_decimator16
    import filter_decimator_pkg::*;
(
    input logic                 i_clkp,
    input logic                 i_rst,
    filter_decimator16_if.slave bus
);
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic [K_W-1:0]          r_k_lat;
    dec_res_t                r_res;
    logic                    r_valid;
    logic                    r_ovf;

    logic [K_W-1:0]          w_k_cur;
    logic [CNT_W-1:0]        w_blk_last;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_blk_end;
    logic                    w_pop;
    logic                    w_drop;
    dec_res_t                w_res;

    // The first sample of a block already uses the freshly sampled exponent.
    assign w_k_cur    = (r_cnt == '0) ? clamp_k(bus.i_log2_dec) : r_k_lat;
    assign w_blk_last = (CNT_W'(1) << w_k_cur) - CNT_W'(1);
    assign w_blk_end  = bus.i_valid && (r_cnt == w_blk_last);
    assign w_sum      = r_acc + ACC_W'(bus.i_data);
    assign w_pop      = r_valid && bus.i_ready;
    assign w_drop     = w_blk_end && r_valid && !bus.i_ready;

    dec_sat_shift u_sat_shift (
        .i_sum (w_sum),
        .i_k   (w_k_cur),
        .o_res (w_res)
    );

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge i_clkp or posedge i_rst) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_k_lat <= '0;
            r_res   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (bus.i_valid) begin
                if (r_cnt == '0) begin
                    r_k_lat <= w_k_cur;
                end
                if (w_blk_end) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            if (w_blk_end && !w_drop) begin
                r_res   <= w_res;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.o_data  = r_res.data;
    assign bus.o_sat   = r_res.sat;
    assign bus.o_valid = r_valid;
    assign bus.o_ovf   = r_ovf;
endmodule

// File: tb/tb_filter_decimator16.sv
// Self-checking bench for filter_decimator16: directed vector table, hand
// sequences for long blocks and reset, and random traffic against a model.
module tb_filter_decimator16;
    import filter_decimator_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    filter_decimator16_if bus();

    filter_decimator16 dut (
        .i_clkp (clk),
        .i_rst  (rst),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: samples of the open block plus the expected output port.
    longint           blk[$];
    int               m_k;
    logic             m_valid;
    logic signed [15:0] m_data;
    logic             m_sat;
    logic             m_ovf;

    typedef struct {
        logic v;
        int   d;
        int   k;
        logic rdy;
        logic clr;
        logic ev;
        int   ed;
        logic es;
        logic eovf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        blk.delete();
        m_k     = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sat   = 1'b0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input longint d, input int k,
                                       input logic rdy, input logic clr);
        bit     done = 0;
        bit     drop = 0;
        bit     pop  = m_valid && rdy;
        longint sum  = 0;
        longint div;
        longint q;
        logic signed [15:0] r_d = '0;
        logic   r_s = 1'b0;
        if (v) begin
            if (blk.size() == 0) m_k = (k > 8) ? 8 : k;
            blk.push_back(d);
            if (blk.size() == (1 << m_k)) begin
                foreach (blk[i]) sum += blk[i];
                div = longint'(1) << m_k;
                q = (sum >= 0) ? sum / div : -((-sum + div - 1) / div);
                if (q > 32767) begin
                    r_d = 16'sd32767; r_s = 1'b1;
                end else if (q < -32768) begin
                    r_d = -16'sd32768; r_s = 1'b1;
                end else begin
                    r_d = 16'(q); r_s = 1'b0;
                end
                blk.delete();
                done = 1;
            end
        end
        if (done && (!m_valid || pop)) begin
            m_valid = 1'b1;
            m_data  = r_d;
            m_sat   = r_s;
        end else begin
            if (done) drop = 1;
            if (pop) m_valid = 1'b0;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endfunction

    task automatic cycle(input logic v, input int d, input int k, input logic rdy, input logic clr);
        bus.i_valid    = v;
        bus.i_data     = d;
        bus.i_log2_dec = 4'(k);
        bus.i_ready    = rdy;
        bus.i_clr_ovf  = clr;
        model_step(v, longint'(d), k, rdy, clr);
        @(posedge clk);
        #1;
        check("model o_valid", bus.o_valid, m_valid);
        if (m_valid) begin
            check("model o_data", bus.o_data, m_data);
            check("model o_sat", bus.o_sat, m_sat);
        end
        check("model o_ovf", bus.o_ovf, m_ovf);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " o_valid"}, bus.o_valid, 0);
        check({tag, " o_data"}, bus.o_data, 0);
        check({tag, " o_sat"}, bus.o_sat, 0);
        check({tag, " o_ovf"}, bus.o_ovf, 0);
    endtask

    function automatic void add(input logic v, input int d, input int k, input logic rdy,
                                input logic clr, input logic ev, input int ed,
                                input logic es, input logic eovf);
        vec_t r;
        r = '{v, d, k, rdy, clr, ev, ed, es, eovf};
        tbl.push_back(r);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_log2_dec = '0;
        bus.i_ready = 1'b0; bus.i_clr_ovf = 1'b0;
        model_reset();
        #12;
        check_zero("reset");
        #5;
        rst = 1'b0;

        // k=2 block average with floor
        add(1, 10, 2, 1, 0, 0, 0, 0, 0);
        add(1, 20, 2, 1, 0, 0, 0, 0, 0);
        add(1, 30, 2, 1, 0, 0, 0, 0, 0);
        add(1, 41, 2, 1, 0, 1, 25, 0, 0);
        add(0, 0, 2, 1, 0, 0, 0, 0, 0);
        // k=0 saturation path
        add(1, 65536, 0, 1, 0, 1, 32767, 1, 0);
        add(1, -70000, 0, 1, 0, 1, -32768, 1, 0);
        add(1, -3, 0, 1, 0, 1, -3, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // negative sum floors toward -inf
        add(1, -3, 1, 1, 0, 0, 0, 0, 0);
        add(1, -4, 1, 1, 0, 1, -4, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        // backpressure drop, clear, then simultaneous pop and load
        add(1, 1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 3, 1, 0, 0, 1, 2, 0, 0);
        add(1, 5, 1, 0, 0, 1, 2, 0, 0);
        add(1, 7, 1, 0, 0, 1, 2, 0, 1);
        add(0, 0, 1, 0, 1, 1, 2, 0, 0);
        add(1, 9, 1, 0, 0, 1, 2, 0, 0);
        add(1, 11, 1, 1, 0, 1, 10, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        // overflow set wins over clear in the same cycle
        add(1, 100, 0, 0, 0, 1, 100, 0, 0);
        add(1, 200, 0, 0, 1, 1, 100, 0, 1);
        add(0, 0, 0, 0, 1, 1, 100, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);
        // exponent change mid-block applies to the next block only
        add(1, 4, 1, 1, 0, 0, 0, 0, 0);
        add(1, 6, 3, 1, 0, 1, 5, 0, 0);
        add(1, 1, 3, 1, 0, 0, 0, 0, 0);
        for (int s = 2; s <= 7; s++) add(1, s, 0, 1, 0, 0, 0, 0, 0);
        add(1, 8, 0, 1, 0, 1, 4, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].rdy, tbl[i].clr);
            check($sformatf("tbl[%0d] o_valid", i), bus.o_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                check($sformatf("tbl[%0d] o_data", i), bus.o_data, tbl[i].ed);
                check($sformatf("tbl[%0d] o_sat", i), bus.o_sat, tbl[i].es);
            end
            check($sformatf("tbl[%0d] o_ovf", i), bus.o_ovf, tbl[i].eovf);
        end

        // k=8 full-scale block: no accumulator wrap, saturates high
        for (int i = 0; i < 256; i++) cycle(1, 32'sh7FFF_FFFF, 8, 1, 0);
        check("k8 full o_valid", bus.o_valid, 1);
        check("k8 full o_data", bus.o_data, 32767);
        check("k8 full o_sat", bus.o_sat, 1);
        for (int i = 0; i < 256; i++) cycle(1, -1, 8, 1, 0);
        check("k8 neg o_valid", bus.o_valid, 1);
        check("k8 neg o_data", bus.o_data, -1);
        check("k8 neg o_sat", bus.o_sat, 0);
        // exponent above the maximum behaves as 8
        for (int i = 0; i < 255; i++) cycle(1, 512, 15, 1, 0);
        check("k15 early o_valid", bus.o_valid, 0);
        cycle(1, 512, 15, 1, 0);
        check("k15 o_valid", bus.o_valid, 1);
        check("k15 o_data", bus.o_data, 512);
        cycle(0, 0, 0, 1, 0);

        // reset mid-block with a held result and overflow pending
        cycle(1, 5, 0, 0, 0);
        cycle(1, 6, 0, 0, 0);
        cycle(1, 100, 2, 0, 0);
        cycle(1, 100, 2, 0, 0);
        check("pre-reset o_ovf", bus.o_ovf, 1);
        bus.i_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_zero("async reset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1, 4, 2, 1, 0);
        cycle(1, 8, 2, 1, 0);
        cycle(1, 12, 2, 1, 0);
        cycle(1, 16, 2, 1, 0);
        check("post-reset o_valid", bus.o_valid, 1);
        check("post-reset o_data", bus.o_data, 10);
        cycle(0, 0, 2, 1, 0);

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic v;
            logic rdy;
            logic clr;
            int   d;
            int   k;
            v   = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 19) == 0);
            k   = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) d = int'($urandom);
            else d = int'($urandom_range(0, 2000)) - 1000;
            cycle(v, d, k, rdy, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/filter_decimator16.md
# filter_decimator16

Decimating block-averager placed directly downstream of the 16-bit first-order low-pass filter. It consumes the filter's 32-bit signed output stream, sums blocks of 2^k samples, and divides by 2^k with an arithmetic shift. The result is saturated to 16-bit signed and presented on a valid/ready port to the slower lock-loop / host-readout logic. A sticky overflow flag reports any result dropped because downstream was not ready.

## Interface
- IN_W, 32, input sample width (signed)
- OUT_W, 16, output width (signed, saturated)
- LOG2_MAX, 8, maximum decimation exponent; accumulator width is IN_W+LOG2_MAX
- i_clkp  in  1  system clock, rising edge
- i_rst  in  1  reset; asynchronous and active-high
- i_data  in  IN_W  signed filter output sample
- i_valid  in  1  sample strobe; one sample accepted per cycle where high
- i_log2_dec  in  4  decimation exponent k; ratio 2^k; values > LOG2_MAX act as LOG2_MAX
- o_data  out  OUT_W  signed averaged result
- o_sat  out  1  o_data was clamped (qualified by o_valid)
- o_valid  out  1  result available
- i_ready  in  1  downstream accepts result when o_valid & i_ready
- o_ovf  out  1  sticky: a completed result was discarded
- i_clr_ovf  in  1  synchronous clear of o_ovf

## Operation
- State: accumulator acc (IN_W+LOG2_MAX bits signed), sample counter cnt (LOG2_MAX+1 bits), latched exponent k_lat, output register {o_data, o_sat, o_valid}, o_ovf.
- At block start (cnt==0 with i_valid), k_lat <= min(i_log2_dec, LOG2_MAX). Changes to i_log2_dec mid-block take effect at the next block only.
- Each accepted sample: if cnt == 2^k_lat − 1, block ends; otherwise acc += sign-extended i_data and cnt++.
- Block end: sum = acc + i_data; res = sum >>> k_lat (arithmetic, floor toward −inf); clamp to [−32768, 32767]; o_sat = clamp occurred; acc <= 0, cnt <= 0.
- k=0: every sample is a block; pure saturation path.
- Output register load: if !o_valid, or o_valid & i_ready in the same cycle, load res and set o_valid. Otherwise keep the old result, drop res, and set o_ovf.
- Pop without new result: o_valid & i_ready clears o_valid next cycle.
- o_ovf: set has priority over i_clr_ovf in the same cycle.
- Accumulator cannot overflow: 2^LOG2_MAX × full-scale IN_W fits IN_W+LOG2_MAX bits.

## Timing
- Reset values (i_rst high, asynchronous): acc=0, cnt=0, k_lat=0, o_data=0, o_sat=0, o_valid=0, o_ovf=0. Reset mid-block discards the partial sum; the first block after release starts with the first i_valid.
- Latency: o_valid rises on the clock edge that accepts the final sample of a block; the result is visible in the following cycle.
- Throughput: one input sample per cycle, sustained. No input backpressure; the input side never stalls.
- o_data/o_sat stable while o_valid & !i_ready.
- Single-cycle combinational path from i_data through add, shift and clamp into the output register. Pipelining is not required at the system clock.

## Structure
- Package filter_decimator_pkg: IN_W/OUT_W/LOG2_MAX defaults, ACC_W = IN_W+LOG2_MAX, OUT_MAX/OUT_MIN constants.
- Sub-module dec_sat_shift: combinational; takes the ACC_W-bit sum and k, returns the OUT_W-bit result plus a sat flag. Reusable by the neighbouring filter stages.
- Top: counter/accumulator datapath, output holding register, and the o_ovf flop.

## Test plan
- k=2, i_ready=1, inputs 10,20,30,41 -> single result 25 (floor 101/4), o_sat=0, o_valid high for exactly one cycle after the 4th sample.
- k=0, input 0x0001_0000 -> o_data=32767, o_sat=1; input −70000 -> o_data=−32768, o_sat=1; input −3 -> −3.
- k=8, 256 samples of 0x7FFF_FFFF -> no internal wrap, o_data=32767, o_sat=1; 256 samples of −1 -> o_data=−1.
- k=1, i_ready=0 for two blocks (1,3 then 5,7) -> o_data holds 2, o_ovf=1; i_clr_ovf pulse -> o_ovf=0; simultaneous pop and new result -> o_valid stays 1 and o_data updates.
- Change i_log2_dec 1->3 after the first sample of a block -> current block completes with 2 samples, next block uses 8; i_rst asserted mid-block -> all outputs 0, next result built only from post-reset samples.
